rob_ctrl: RTL
=============

ROB_CTRL -- requirements
Module: rob_ctrl

Interface
REQ-001 The block SHALL have parameter NUM_ENTRIES, default 32: number of re-order buffer entries, a power of two.
REQ-002 The block SHALL have parameter ADDR_LEN, default 5: entry index width, log2(NUM_ENTRIES).
REQ-003 The block SHALL have port clk_i, input, 1 bit: single clock, all state updates on its rising edge.
REQ-004 The block SHALL have port reset_i, input, 1 bit: reset, asynchronous, active-low.
REQ-005 The block SHALL have port alloc_valid_i, input, 1 bit: dispatch requests one entry.
REQ-006 The block SHALL have port alloc_ready_o, output, 1 bit: an entry can be accepted this cycle.
REQ-007 The block SHALL have port alloc_tag_o, output, ADDR_LEN bits: index granted to dispatch, equal to the tail index.
REQ-008 The block SHALL have port cmpl_valid_i, input, 1 bit: an execution unit reports completion.
REQ-009 The block SHALL have port cmpl_tag_i, input, ADDR_LEN bits: index of the completed entry.
REQ-010 The block SHALL have port commit_valid_o, output, 1 bit: the head entry is ready to retire.
REQ-011 The block SHALL have port commit_ready_i, input, 1 bit: the retire stage accepts the head entry.
REQ-012 The block SHALL have port commit_tag_o, output, ADDR_LEN bits: head index.
REQ-013 The block SHALL have port flush_i, input, 1 bit: squash all in-flight entries.
REQ-014 The block SHALL have port count_o, output, ADDR_LEN+1 bits: number of occupied entries.
REQ-015 The block SHALL have ports empty_o and full_o, outputs, 1 bit each: occupancy status.

Function
REQ-016 The block SHALL keep head and tail pointers of ADDR_LEN+1 bits each, the MSB being a wrap bit; the index is the low ADDR_LEN bits, and the pointers wrap modulo 2*NUM_ENTRIES.
REQ-017 The block SHALL assert empty_o when head equals tail, and full_o when the indices are equal and the wrap bits differ.
REQ-018 The block SHALL drive count_o as tail minus head, modulo 2*NUM_ENTRIES, giving a range of 0..NUM_ENTRIES.
REQ-019 The block SHALL hold per-entry valid and done bit vectors, each NUM_ENTRIES wide.
REQ-020 The block SHALL implement a state machine with states RUN and FLUSH; reset enters RUN.
REQ-021 The block SHALL drive alloc_ready_o = (state==RUN) & ~full_o, computed from registered state only; a commit in the same cycle does not free a slot for allocation in that cycle.
REQ-022 On alloc_valid_i & alloc_ready_o, the block SHALL, at the clock edge, set valid[tail], clear done[tail] and increment tail.
REQ-023 On cmpl_valid_i in RUN with valid[cmpl_tag_i]=1, the block SHALL set done[cmpl_tag_i] at the clock edge; a completion to an invalid entry SHALL be ignored.
REQ-024 The block SHALL drive commit_valid_o = (state==RUN) & ~empty_o & done[head] from registered bits, so completion-to-commit latency is 1 cycle.
REQ-025 On commit_valid_o & commit_ready_i, the block SHALL clear valid[head] and done[head] and increment head.
REQ-026 A simultaneous allocation, completion and commit SHALL all take effect in the same cycle; with allocation and commit together, count_o is unchanged.
REQ-027 A completion for the head entry in the same cycle as a commit handshake SHALL be ignored, since the head entry is already done.
REQ-028 On flush_i=1 in any state, the block SHALL enter FLUSH at the next edge; flush_i SHALL take priority over allocation, completion and commit in that cycle, none of which take effect.
REQ-029 In FLUSH, the block SHALL hold alloc_ready_o=0 and commit_valid_o=0, clear all valid and done bits, set head=tail=0, and return to RUN after exactly 1 cycle, unless flush_i is still 1, in which case it stays in FLUSH.
REQ-030 The block SHALL ignore cmpl_valid_i while in FLUSH.

Reset
REQ-031 While reset_i=0, asynchronously: head=0, tail=0, valid=0, done=0, state=RUN.
REQ-032 Output values during reset: alloc_ready_o=1, alloc_tag_o=0, commit_valid_o=0, commit_tag_o=0, count_o=0, empty_o=1, full_o=0.
REQ-033 Reset asserted mid-operation SHALL discard all entries immediately, without waiting for a clock edge.

Verification
REQ-034 Fill test: allocate 32 times with no commits -> alloc_tag_o steps 0..31, count_o reaches 32, full_o=1, alloc_ready_o=0; a 33rd request is not accepted.
REQ-035 Out-of-order completion: allocate tags 0..2, complete 2 then 0 -> commit_valid_o rises 1 cycle after tag 0 completes; tag 0 commits, then the pipeline stalls until tag 1 completes; tags retire in order 0,1,2.
REQ-036 Wrap-around: run 40 allocations, each completed and committed -> tags wrap 31->0, empty_o and full_o are never wrongly asserted, and count_o stays at or below 32.
REQ-037 Full with simultaneous commit: when full and the head is done, assert commit_ready_i and alloc_valid_i together -> the commit occurs, the allocation is refused this cycle and accepted the next cycle, and count_o goes 32->31->32.
REQ-038 Flush: with 5 entries in flight, pulse flush_i together with alloc_valid_i and cmpl_valid_i -> 1 FLUSH cycle with both ready/valid outputs low; then count_o=0, alloc_tag_o=0, and the stale cmpl_tag_i has no effect.
REQ-039 Asynchronous reset: drop reset_i between clock edges with 10 entries in flight -> count_o=0 and empty_o=1 before the next edge.

Source files
------------

// File: rtl/rob_ctrl.sv
// Re-order buffer control: wrap-bit head/tail pointers with per-entry valid/done
// tracking, in-order commit, and a single-cycle flush state.
module rob_ctrl #(
    parameter int NUM_ENTRIES = 32,
    parameter int ADDR_LEN    = 5
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic                alloc_valid_i,
    output logic                alloc_ready_o,
    output logic [ADDR_LEN-1:0] alloc_tag_o,
    input  logic                cmpl_valid_i,
    input  logic [ADDR_LEN-1:0] cmpl_tag_i,
    output logic                commit_valid_o,
    input  logic                commit_ready_i,
    output logic [ADDR_LEN-1:0] commit_tag_o,
    input  logic                flush_i,
    output logic [ADDR_LEN:0]   count_o,
    output logic                empty_o,
    output logic                full_o
);

    localparam logic [0:0]        ST_RUN   = 1'b0;
    localparam logic [0:0]        ST_FLUSH = 1'b1;
    localparam logic [ADDR_LEN:0] PTR_ONE  = 1;

    logic [0:0]             state_q, state_d;
    logic [ADDR_LEN:0]      head_q, head_d;
    logic [ADDR_LEN:0]      tail_q, tail_d;
    logic [NUM_ENTRIES-1:0] valid_q, valid_d;
    logic [NUM_ENTRIES-1:0] done_q, done_d;

    logic [ADDR_LEN-1:0] head_idx;
    logic [ADDR_LEN-1:0] tail_idx;
    logic                in_run;
    logic                alloc_fire;
    logic                commit_fire;
    logic                cmpl_fire;

    assign head_idx = head_q[ADDR_LEN-1:0];
    assign tail_idx = tail_q[ADDR_LEN-1:0];
    assign in_run   = (state_q == ST_RUN);

    // Status outputs: all derived from registered state only.
    assign empty_o        = (head_q == tail_q);
    assign full_o         = (head_idx == tail_idx) && (head_q[ADDR_LEN] != tail_q[ADDR_LEN]);
    assign count_o        = tail_q - head_q;
    assign alloc_ready_o  = in_run && !full_o;
    assign alloc_tag_o    = tail_idx;
    assign commit_valid_o = in_run && !empty_o && done_q[head_idx];
    assign commit_tag_o   = head_idx;

    // A flush request squashes every other handshake in its cycle.
    assign alloc_fire  = alloc_valid_i && alloc_ready_o && !flush_i;
    assign commit_fire = commit_valid_o && commit_ready_i && !flush_i;

    // The head entry is already done when it commits, so a late completion for it is dropped.
    assign cmpl_fire = cmpl_valid_i && in_run && !flush_i && valid_q[cmpl_tag_i]
                       && !(commit_fire && (cmpl_tag_i == head_idx));

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        valid_d = valid_q;
        done_d  = done_q;

        if (state_q == ST_FLUSH) begin
            valid_d = '0;
            done_d  = '0;
            head_d  = '0;
            tail_d  = '0;
            state_d = flush_i ? ST_FLUSH : ST_RUN;
        end else if (flush_i) begin
            state_d = ST_FLUSH;
        end else begin
            if (cmpl_fire) begin
                done_d[cmpl_tag_i] = 1'b1;
            end
            if (commit_fire) begin
                valid_d[head_idx] = 1'b0;
                done_d[head_idx]  = 1'b0;
                head_d            = head_q + PTR_ONE;
            end
            // Allocation never targets the head slot while a commit is possible (not full).
            if (alloc_fire) begin
                valid_d[tail_idx] = 1'b1;
                done_d[tail_idx]  = 1'b0;
                tail_d            = tail_q + PTR_ONE;
            end
        end
    end

    // NOTE: valid/done are control flops, not storage, so they are cleared by reset;
    // a reset mid-operation must discard every entry at once.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            // NOTE: sequential state uses non-blocking assignments so all flops update together.
            state_q <= ST_RUN;
            head_q  <= '0;
            tail_q  <= '0;
            valid_q <= '0;
            done_q  <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            valid_q <= valid_d;
            done_q  <= done_d;
        end
    end

    // Structural invariants of the pointer/bit-vector bookkeeping.
    a_count_range: assert property (@(posedge clk_i) disable iff (!reset_i)
        int'(count_o) <= NUM_ENTRIES);
    a_empty_full_excl: assert property (@(posedge clk_i) disable iff (!reset_i)
        !(empty_o && full_o));
    a_valid_matches_count: assert property (@(posedge clk_i) disable iff (!reset_i)
        $countones(valid_q) == int'(count_o));
    a_done_subset_valid: assert property (@(posedge clk_i) disable iff (!reset_i)
        (done_q & ~valid_q) == '0);
    a_commit_valid_head: assert property (@(posedge clk_i) disable iff (!reset_i)
        commit_valid_o |-> valid_q[head_idx]);

endmodule
